// File: rtl/dds_pkg.sv
// Shared definitions for the DDS wavetable responder: loader FSM encoding,
// loader byte framing and bank index constants.
package dds_pkg;

    // Each table word arrives as two loader bytes, high byte first.
    localparam int unsigned BYTES_PER_WORD = 2;

    // Loader FSM state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD_HI = 2'd1;
    localparam logic [1:0] ST_LOAD_LO = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Bank indices.
    localparam logic BANK_0 = 1'b0;
    localparam logic BANK_1 = 1'b1;

endpackage

// File: rtl/dds_wavetable_responder_if.sv
// DDS table read port plus host byte-loader handshake.
//   i_ram_isr / i_ram_address / o_ram_data : DDS read strobe, address, data
//   i_load_start / i_load_commit           : loader control
//   i_wr_byte / i_wr_valid / o_wr_ready    : loader byte handshake
//   o_loading / o_load_done / o_load_error : loader status
//   o_bank                                 : active bank index
// master = DDS generator + host side, slave = responder.
interface dds_wavetable_responder_if #(
    parameter int unsigned _RAM_ADD_WIDTH = 10,
    parameter int unsigned _RAM_DAT_WIDTH = 16
);
    logic                      i_ram_isr;
    logic [_RAM_ADD_WIDTH-1:0] i_ram_address;
    logic [_RAM_DAT_WIDTH-1:0] o_ram_data;
    logic                      i_load_start;
    logic [7:0]                i_wr_byte;
    logic                      i_wr_valid;
    logic                      o_wr_ready;
    logic                      i_load_commit;
    logic                      o_loading;
    logic                      o_load_done;
    logic                      o_load_error;
    logic                      o_bank;

    modport master (
        output i_ram_isr, i_ram_address, i_load_start, i_wr_byte, i_wr_valid, i_load_commit,
        input  o_ram_data, o_wr_ready, o_loading, o_load_done, o_load_error, o_bank
    );

    modport slave (
        input  i_ram_isr, i_ram_address, i_load_start, i_wr_byte, i_wr_valid, i_load_commit,
        output o_ram_data, o_wr_ready, o_loading, o_load_done, o_load_error, o_bank
    );
endinterface

// File: rtl/dds_wavetable_bank.sv
// One wavetable bank: simple dual-port RAM, write port plus synchronous
// read port with an enable.
//   clk_i, rst_i       : clock, async active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i       : read enable / address
//   rdata_o            : registered read data, holds when re_i is low
module dds_wavetable_bank #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage is not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dds_wavetable_responder.sv
// Double-buffered DDS wavetable responder. The DDS reads the active bank
// while the host byte loader fills the shadow bank; a commit from DONE swaps
// the banks. Ports: i_clk, i_reset (async active-high), bus (slave modport).
module dds_wavetable_responder
    import dds_pkg::*;
#(
    parameter int unsigned _RAM_ADD_WIDTH = 10,
    parameter int unsigned _RAM_DAT_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    dds_wavetable_responder_if.slave  bus
);
    localparam int unsigned AW = _RAM_ADD_WIDTH;
    localparam int unsigned DW = _RAM_DAT_WIDTH;
    localparam int unsigned WORD_BITS = 8 * BYTES_PER_WORD;
    localparam logic [AW-1:0] PTR_LAST = '1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    hi_q, hi_d;
    logic          bank_q, bank_d;
    logic          rd_sel_q;
    logic          wr_ready_q, wr_ready_d;
    logic          loading_q, loading_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          accept_c;
    logic          we_c;
    logic [WORD_BITS-1:0] word_full_c;
    logic [DW-1:0] wr_word_c;
    logic [DW-1:0] rd_data0, rd_data1;

    assign accept_c    = bus.i_wr_valid & wr_ready_q;
    assign word_full_c = {hi_q, bus.i_wr_byte};
    assign wr_word_c   = DW'(word_full_c);

    // Loader next-state and status outputs. Start outranks a same-cycle byte
    // and a same-cycle commit.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        bank_d  = bank_q;
        we_c    = 1'b0;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_load_start) begin
                    state_d = ST_LOAD_HI;
                    ptr_d   = '0;
                end
                error_d = bus.i_load_commit;
            end
            ST_LOAD_HI: begin
                if (bus.i_load_start) begin
                    ptr_d = '0;
                    hi_d  = '0;
                end else if (accept_c) begin
                    hi_d    = bus.i_wr_byte;
                    state_d = ST_LOAD_LO;
                end
                error_d = bus.i_load_commit;
            end
            ST_LOAD_LO: begin
                if (bus.i_load_start) begin
                    state_d = ST_LOAD_HI;
                    ptr_d   = '0;
                    hi_d    = '0;
                end else if (accept_c) begin
                    we_c    = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    state_d = (ptr_q == PTR_LAST) ? ST_DONE : ST_LOAD_HI;
                end
                error_d = bus.i_load_commit;
            end
            ST_DONE: begin
                if (bus.i_load_start) begin
                    state_d = ST_LOAD_HI;
                    ptr_d   = '0;
                end else if (bus.i_load_commit) begin
                    bank_d  = ~bank_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_ready_d = (state_d == ST_LOAD_HI) || (state_d == ST_LOAD_LO);
        loading_d  = wr_ready_d;
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hi_q       <= '0;
            bank_q     <= BANK_0;
            wr_ready_q <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hi_q       <= hi_d;
            bank_q     <= bank_d;
            wr_ready_q <= wr_ready_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Remembers which bank the latest strobe read, so a commit edge never
    // changes data already returned.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_sel_q <= BANK_0;
        end else if (bus.i_ram_isr) begin
            rd_sel_q <= bank_q;
        end
    end

    // Writes go only to the shadow bank.
    dds_wavetable_bank #(.AW(AW), .DW(DW)) u_bank0 (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .we_i    (we_c & (bank_q == BANK_1)),
        .waddr_i (ptr_q),
        .wdata_i (wr_word_c),
        .re_i    (bus.i_ram_isr),
        .raddr_i (bus.i_ram_address),
        .rdata_o (rd_data0)
    );

    dds_wavetable_bank #(.AW(AW), .DW(DW)) u_bank1 (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .we_i    (we_c & (bank_q == BANK_0)),
        .waddr_i (ptr_q),
        .wdata_i (wr_word_c),
        .re_i    (bus.i_ram_isr),
        .raddr_i (bus.i_ram_address),
        .rdata_o (rd_data1)
    );

    assign bus.o_ram_data   = (rd_sel_q == BANK_1) ? rd_data1 : rd_data0;
    assign bus.o_wr_ready   = wr_ready_q;
    assign bus.o_loading    = loading_q;
    assign bus.o_load_done  = done_q;
    assign bus.o_load_error = error_q;
    assign bus.o_bank       = bank_q;
endmodule

// File: tb/tb_dds_wavetable_responder.sv
// Scoreboard bench for dds_wavetable_responder: read expectations are queued
// from a bench-side model of both banks when a strobe is driven and popped
// when the registered data appears.
module tb_dds_wavetable_responder;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int NWORDS = 1 << AW;

    logic clk;
    logic rst;

    dds_wavetable_responder_if #(._RAM_ADD_WIDTH(AW), ._RAM_DAT_WIDTH(DW)) bus ();

    dds_wavetable_responder #(._RAM_ADD_WIDTH(AW), ._RAM_DAT_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [2][NWORDS];
    logic [15:0] sb [$];
    int tb_bank = 0;
    logic rd_on = 1'b0;
    int rd_addr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int pat, input int a);
        case (pat)
            0:       return 16'(a);
            1:       return 16'hA5A5;
            2:       return 16'(a * 7 + 3);
            default: return 16'(~a);
        endcase
    endfunction

    // Read monitor: every strobed edge produces one word one cycle later.
    always @(posedge clk) begin
        if (bus.i_ram_isr && !rst) begin
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got read data 0x%0h with no expectation queued", bus.o_ram_data);
            end else begin
                check_eq("rd_data", 32'(bus.o_ram_data), 32'(sb.pop_front()));
            end
        end
    end

    // One clock cycle of stimulus; reads follow rd_on/rd_addr.
    task automatic step(input logic v, input logic [7:0] b, input logic st, input logic cm);
        @(negedge clk);
        bus.i_wr_valid    = v;
        bus.i_wr_byte     = b;
        bus.i_load_start  = st;
        bus.i_load_commit = cm;
        bus.i_ram_isr     = rd_on;
        bus.i_ram_address = AW'(rd_addr);
        if (rd_on) sb.push_back(model[tb_bank][rd_addr]);
        @(posedge clk);
        #1;
    endtask

    task automatic load_range(input int pat, input int first, input int last, input logic toggle);
        logic [15:0] w;
        for (int a = first; a <= last; a++) begin
            w = word_of(pat, a);
            step(1'b1, w[15:8], 1'b0, 1'b0);
            if (toggle) step(1'b0, 8'h00, 1'b0, 1'b0);
            if (a == NWORDS - 1) check_eq("done_before_last", 32'(bus.o_load_done), 32'd0);
            step(1'b1, w[7:0], 1'b0, 1'b0);
            if (toggle) step(1'b0, 8'h00, 1'b0, 1'b0);
            model[1 - tb_bank][a] = w;
        end
        if (last == NWORDS - 1) begin
            check_eq("done_after_last", 32'(bus.o_load_done), 32'd1);
            check_eq("loading_after_last", 32'(bus.o_loading), 32'd0);
            check_eq("ready_after_last", 32'(bus.o_wr_ready), 32'd0);
        end
    endtask

    task automatic commit();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        tb_bank = 1 - tb_bank;
        check_eq("bank_after_commit", 32'(bus.o_bank), 32'(tb_bank));
        check_eq("err_on_commit", 32'(bus.o_load_error), 32'd0);
    endtask

    task automatic read_list(input int pat_sel);
        int addrs [5];
        addrs = '{NWORDS - 1, 0, 1, 341, 512 + pat_sel};
        rd_on = 1'b1;
        foreach (addrs[i]) begin
            rd_addr = addrs[i];
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        rd_on = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.i_ram_isr = 1'b0;
        bus.i_ram_address = '0;
        bus.i_load_start = 1'b0;
        bus.i_wr_byte = '0;
        bus.i_wr_valid = 1'b0;
        bus.i_load_commit = 1'b0;

        // Asynchronous reset applied between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_ram_data", 32'(bus.o_ram_data), 32'd0);
        check_eq("rst_bank", 32'(bus.o_bank), 32'd0);
        check_eq("rst_ready", 32'(bus.o_wr_ready), 32'd0);
        check_eq("rst_loading", 32'(bus.o_loading), 32'd0);
        check_eq("rst_done", 32'(bus.o_load_done), 32'd0);
        check_eq("rst_error", 32'(bus.o_load_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Bytes offered in IDLE are ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("idle_no_load", 32'(bus.o_loading), 32'd0);

        // Full load value = address, commit, read back.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("start_loading", 32'(bus.o_loading), 32'd1);
        check_eq("start_ready", 32'(bus.o_wr_ready), 32'd1);
        load_range(0, 0, NWORDS - 1, 1'b0);
        commit();
        check_eq("idle_after_commit", 32'(bus.o_load_done), 32'd0);
        read_list(0);

        // Continuous reads of address 5 across a reload and commit.
        rd_on = 1'b1;
        rd_addr = 5;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        load_range(1, 0, NWORDS - 1, 1'b0);
        commit();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        rd_on = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Commit mid-load is rejected with a one-cycle error pulse.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        load_range(2, 0, 9, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("err_pulse", 32'(bus.o_load_error), 32'd1);
        check_eq("err_bank", 32'(bus.o_bank), 32'(tb_bank));
        check_eq("err_loading", 32'(bus.o_loading), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("err_one_cycle", 32'(bus.o_load_error), 32'd0);
        check_eq("err_still_loading", 32'(bus.o_loading), 32'd1);

        // Restart discards a pending hi byte; the load then resumes at word 1.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hDE, 1'b0, 1'b0);
        step(1'b1, 8'hAD, 1'b0, 1'b0);
        step(1'b1, 8'hBE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0);
        model[1 - tb_bank][0] = 16'h1234;
        check_eq("restart_not_done", 32'(bus.o_load_done), 32'd0);
        load_range(3, 1, NWORDS - 1, 1'b0);
        commit();
        read_list(1);

        // Valid toggling every cycle; bytes offered in DONE are ignored.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        load_range(2, 0, NWORDS - 1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h77, 1'b0, 1'b0);
            check_eq("done_no_ready", 32'(bus.o_wr_ready), 32'd0);
            check_eq("done_holds", 32'(bus.o_load_done), 32'd1);
        end
        commit();
        read_list(2);

        // Start and commit together in DONE: reload starts, no swap.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        load_range(0, 0, NWORDS - 1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("stcm_bank", 32'(bus.o_bank), 32'(tb_bank));
        check_eq("stcm_loading", 32'(bus.o_loading), 32'd1);
        check_eq("stcm_done", 32'(bus.o_load_done), 32'd0);
        check_eq("stcm_error", 32'(bus.o_load_error), 32'd0);
        load_range(3, 0, NWORDS - 1, 1'b0);
        commit();
        read_list(3);

        // Asynchronous reset mid-load.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_bank", 32'(bus.o_bank), 32'd0);
        check_eq("midrst_loading", 32'(bus.o_loading), 32'd0);
        check_eq("midrst_ready", 32'(bus.o_wr_ready), 32'd0);
        check_eq("midrst_data", 32'(bus.o_ram_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_wavetable_responder.md
Name: dds_wavetable_responder

Overview:
Memory-side responder for the DDS lookup-table read interface: serves the carrier, AM and FM read strobes/addresses with table words. Holds two banks (active/shadow) per table. The host byte loader fills the shadow bank while the DDS keeps reading the active bank, then a commit swaps the banks glitch-free. One instance per table (carrier, AM, FM).

Parameters:
_RAM_ADD_WIDTH, 10, table address width; each bank holds 2^_RAM_ADD_WIDTH words
_RAM_DAT_WIDTH, 16, table word width; must be 9..16 (two bytes per word)

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_ram_isr  input  1  read strobe from the DDS generator
i_ram_address  input  _RAM_ADD_WIDTH  read address from the DDS generator
o_ram_data  output  _RAM_DAT_WIDTH  read data to the DDS generator
i_load_start  input  1  begin (or restart) loading the shadow bank
i_wr_byte  input  8  loader byte, high byte of each word first
i_wr_valid  input  1  loader byte valid
o_wr_ready  output  1  loader may accept a byte this cycle
i_load_commit  input  1  swap the active and shadow banks
o_loading  output  1  high while the FSM is in LOAD_HI or LOAD_LO
o_load_done  output  1  high in DONE; the shadow bank is full
o_load_error  output  1  one-cycle pulse when a commit is rejected
o_bank  output  1  index of the active bank

Behaviour:
- Reset (async, active-high) sets: o_ram_data=0, o_bank=0, FSM=IDLE, write pointer=0, hi-byte register=0, o_wr_ready=0, o_loading=0, o_load_done=0, o_load_error=0. Memory contents are not reset.
- Read port:
  - i_ram_isr=1 at a clock edge registers o_ram_data <= bank[o_bank][i_ram_address]. Latency is 1 cycle.
  - i_ram_isr=0 holds o_ram_data.
  - Back-to-back strobes are supported every cycle.
- A write to the shadow bank never affects the active bank, even at the same address in the same cycle.
- Loader FSM states: IDLE, LOAD_HI, LOAD_LO, DONE.
  - IDLE: i_load_start -> LOAD_HI, pointer=0.
  - LOAD_HI: a byte is accepted when i_wr_valid & o_wr_ready; it is latched into the hi register -> LOAD_LO.
  - LOAD_LO: an accepted byte writes the word {hi,lo}[_RAM_DAT_WIDTH-1:0] to bank[~o_bank][pointer] and increments the pointer. If the pointer was 2^A-1 it wraps to 0 and the FSM goes to DONE; otherwise it goes to LOAD_HI.
  - DONE: i_load_commit toggles o_bank -> IDLE. i_load_start -> LOAD_HI, pointer=0, which allows a reload without commit.
  - o_wr_ready=1 only in LOAD_HI and LOAD_LO.
- A read in the same cycle as the commit still uses the old bank. The first read after the commit edge uses the new bank.
- i_load_start in LOAD_HI or LOAD_LO aborts the load: pointer=0 -> LOAD_HI, and any pending hi byte is discarded. Start has priority over a byte accepted in the same cycle.
- i_load_commit in IDLE, LOAD_HI or LOAD_LO is ignored and pulses o_load_error for 1 cycle.
- Start and commit asserted together in DONE: start wins, and no swap occurs.
- Asynchronous reset mid-load returns to IDLE with o_bank=0. Partial shadow contents are left as-is, and the host must reload.

Decomposition:
- Shared package `dds_pkg`: loader FSM state encoding, BYTES_PER_WORD=2, bank index constants.
- Sub-module `dds_wavetable_bank`: a simple dual-port RAM with a synchronous read port and a write port, instantiated twice. The read mux by o_bank and the loader FSM stay at top level.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> o_ram_data=0, o_bank=0, o_wr_ready=0 immediately, with no clock edge needed.
2. Load 1024 words of value = address (bytes hi, lo), then commit. Strobe addr 0x3FF -> o_ram_data=0x03FF one cycle later. o_load_done rises after the 2048th byte; o_bank=1.
3. Keep reading addr 5 continuously while reloading with 0xA5A5 at every address -> o_ram_data stays 0x0005 until the cycle after commit, then reads 0xA5A5.
4. Commit issued with 10 words loaded -> o_load_error pulses 1 cycle; o_bank and the FSM state are unchanged.
5. Start, then send 3 bytes, then assert start again, then send 0x12, 0x34 -> the word at addr 0 of the shadow bank is 0x1234; the pointer is 1.
6. i_wr_valid toggled 1/0 every cycle during a full load -> all words are correct, and no byte is accepted while o_wr_ready=0 (i.e. in IDLE or DONE).
